// File: rtl/gf7_serial_mult_if.sv
// Operand/result handshake bundle for the bit-serial GF(2^7) multiplier.
// The master side supplies operands and consumes the product.
interface gf7_serial_mult_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] p;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p
  );
endinterface

// File: rtl/gf7_serial_mult.sv
// Bit-serial GF(2^7) multiplier, f(x) = x^7+x^5+x^4+x^3+x^2+x+1.
// MSB-first Horner evaluation with the reduction folded into every shift.
module gf7_serial_mult #(
  parameter int         M       = 7,
  parameter logic [6:0] POLY_LO = 7'h3F,
  parameter int         CNT_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  gf7_serial_mult_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [M-1:0]       a_reg, b_reg, acc, acc_next, acc_shift;
  logic [M-1:0]       p_reg;
  logic [CNT_W-1:0]   cnt;
  logic               accept, take;

  // Bit 7 of each operand is deliberately ignored.
  wire unused_op_msbs = &{1'b0, bus.a[7], bus.b[7]};

  assign accept = (state == IDLE) && bus.in_valid;
  assign take   = (state == DONE) && bus.out_ready;

  // acc*x mod f, then add a when the current multiplier bit is set.
  always_comb begin
    acc_shift = {acc[M-2:0], 1'b0} ^ (acc[M-1] ? POLY_LO : '0);
    acc_next  = acc_shift ^ (b_reg[cnt] ? a_reg : '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (accept) state_next = RUN;
      end
      RUN: begin
        if (cnt == '0) state_next = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (take) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: these are plain registers, not a memory, so all of them are reset;
  // an abort mid-operation therefore leaves p cleared rather than stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
      p_reg <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_reg <= bus.a[M-1:0];
            b_reg <= bus.b[M-1:0];
            acc   <= '0;
            cnt   <= CNT_W'(M - 1);
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) p_reg <= acc_next;
        end
        default: ;
      endcase
    end
  end

  assign bus.p = {1'b0, p_reg};

endmodule

// File: tb/tb_gf7_serial_mult.sv
// Directed and random checks of gf7_serial_mult against a multiply-then-reduce
// reference model.
module tb_gf7_serial_mult;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  gf7_serial_mult_if bus ();

  gf7_serial_mult dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Full 13-bit carry-less product, then long division by f (0xBF).
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [12:0] pr;
    pr = '0;
    for (int i = 0; i < 7; i++)
      if (y[i]) pr = pr ^ (13'(x[6:0]) << i);
    for (int i = 12; i >= 7; i--)
      if (pr[i]) pr = pr ^ (13'h0BF << (i - 7));
    return {1'b0, pr[6:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one operation, checks latency and product, then retires it.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input bit stalls);
    int n;
    int cycles;
    logic [7:0] want;
    want = gf_mul(av, bv);
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    check("in_ready_before_op", 32'(bus.in_ready), 32'd1);
    bus.a = av;
    bus.b = bv;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.a = 8'($urandom);
    bus.b = 8'($urandom);
    cycles = 0;
    while (!bus.out_valid && cycles < 20) begin
      if (stalls) bus.out_ready = 1'($urandom_range(0, 1));
      tick();
      cycles++;
    end
    bus.out_ready = 1'b0;
    check("latency", 32'(cycles), 32'd7);
    check("product", 32'(bus.p), 32'(want));
    n = 0;
    do begin
      bus.out_ready = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end while (bus.out_valid && n < 50);
    bus.out_ready = 1'b0;
    check("out_valid_after_take", 32'(bus.out_valid), 32'd0);
    check("in_ready_after_take", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] held_p;
    int n;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #22;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_p", 32'(bus.p), 32'd0);
    rst = 1'b0;
    tick();

    // x * x^6 = x^7 -> 0x3F, with exact 7-cycle latency
    run_op(8'h02, 8'h40, 1'b0);
    check("x_x6", 32'(bus.p), 32'h3F);
    // x^12 and commutation
    run_op(8'h40, 8'h40, 1'b0);
    check("x12", 32'(bus.p), 32'h5B);
    run_op(8'h40, 8'h02, 1'b0);
    check("x6_x", 32'(bus.p), 32'h3F);
    // Operand bit 7 ignored; zero operand
    run_op(8'h81, 8'h01, 1'b0);
    check("msb_ignored", 32'(bus.p), 32'h01);
    run_op(8'h00, 8'h7F, 1'b0);
    check("zero_operand", 32'(bus.p), 32'h00);
    run_op(8'h7F, 8'h7F, 1'b0);

    // Backpressure in DONE: output held, new request refused
    bus.a = 8'h13;
    bus.b = 8'h57;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    check("stall_latency", 32'(n), 32'd7);
    held_p = bus.p;
    check("stall_product", 32'(held_p), 32'(gf_mul(8'h13, 8'h57)));
    bus.a = 8'h7F;
    bus.b = 8'h7F;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_out_valid", 32'(bus.out_valid), 32'd1);
      check("stall_p", 32'(bus.p), 32'(held_p));
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("stall_released", 32'(bus.out_valid), 32'd0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.out_valid) n++;
    end
    check("stall_request_dropped", 32'(n), 32'd0);

    // Reset during the 3rd RUN cycle aborts the operation
    bus.a = 8'h02;
    bus.b = 8'h40;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #2;
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_p", 32'(bus.p), 32'd0);
    #3;
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.out_valid) n++;
    end
    check("abort_no_result", 32'(n), 32'd0);
    check("abort_p_kept", 32'(bus.p), 32'd0);
    run_op(8'h02, 8'h40, 1'b0);
    check("after_abort", 32'(bus.p), 32'h3F);

    // Random back-to-back operations with random stalls
    for (int i = 0; i < 500; i++)
      run_op(8'($urandom), 8'($urandom), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
